work_ram_arbiter: RTL and testbench
===================================

WORK_RAM_ARBITER -- requirements
Module: work_ram_arbiter

Interface
REQ-001 Parameter AW, default 12, SHALL set the work RAM address width.
REQ-002 Parameter DW, default 8, SHALL set the work RAM data width.
REQ-003 clk  in  1  system clock (clk_sys domain); the block SHALL use this single clock.
REQ-004 RESET_N  in  1  reset, asynchronous assert, active-low.
REQ-005 vblank  in  1  core vertical blank; secondary access window.
REQ-006 cpu_addr/cpu_wdata/cpu_we  in  AW/DW/1  CPU-side RAM request, always presented.
REQ-007 cpu_hold  out  1  stall to CPU clock-enable while a secondary owns the port.
REQ-008 rq_req[1:0]  in  2  secondary requests: bit0 hiscore engine, bit1 OSD upload reader.
REQ-009 rq_addr0/rq_addr1, rq_wdata0/rq_wdata1, rq_we[1:0]  in  AW, DW, 2  secondary request payloads.
REQ-010 rq_ack[1:0]  out  2  one-cycle completion pulse per requester.
REQ-011 rq_rdata  out  DW  read data, valid in the rq_ack cycle.
REQ-012 ram_addr/ram_wdata/ram_we  out  AW/DW/1  muxed RAM port.
REQ-013 ram_rdata  in  DW  RAM read data, one-cycle synchronous latency.

Function
REQ-014 FSM states SHALL be IDLE, HOLD, SETUP, XFER, DONE.
REQ-015 IDLE: ram_* SHALL pass cpu_* through combinationally; cpu_hold=0.
REQ-016 IDLE->HOLD SHALL occur only when vblank=1 and any rq_req bit=1; the winner is latched at this transition.
REQ-017 Arbitration SHALL be round-robin: with both requesting, the winner is the requester not served last; last-served resets to bit1 so bit0 wins first.
REQ-018 HOLD: cpu_hold=1 for exactly 2 cycles, with the CPU pass-through still active, so an in-flight CPU write completes; then go to SETUP.
REQ-019 SETUP: ram_addr/ram_wdata SHALL be the winner's latched payload; ram_we=0.
REQ-020 XFER: ram_we SHALL equal the latched rq_we; address/data held.
REQ-021 DONE: rq_ack[winner]=1 for one cycle; rq_rdata=ram_rdata (captured from the XFER address); ram_we=0.
REQ-022 DONE->SETUP SHALL occur if vblank=1 and another request is pending (arbitrated per REQ-017), keeping cpu_hold=1; otherwise DONE->IDLE with cpu_hold dropping in IDLE.
REQ-023 Payloads SHALL be latched at HOLD/DONE selection; requester changes after selection SHALL be ignored until ack.
REQ-024 A requester SHALL keep rq_req high until its ack; deassertion before ack SHALL abort nothing: the access completes and the ack is still issued.
REQ-025 vblank falling mid-transfer SHALL NOT abort: the current access finishes, then IDLE.
REQ-026 Maximum secondary accesses per window SHALL be unbounded while vblank=1; each access costs 3 cycles (SETUP, XFER, DONE) after the initial 2-cycle HOLD.
REQ-027 rq_req asserted while vblank=0 SHALL wait with no ack and no RAM effect.
REQ-028 cpu_we SHALL never reach ram_we outside IDLE and HOLD.

Reset
REQ-029 On RESET_N=0, asynchronously: state=IDLE, cpu_hold=0, rq_ack=0, rq_rdata=0, last-served=bit1, latches=0.
REQ-030 Reset mid-transfer SHALL drop the access with no ack; after release, the requester re-arbitrates normally.

Structure
REQ-031 State encoding enum and requester index constants (RQ_HISCORE=0, RQ_UPLOAD=1) SHALL live in a shared core package.
REQ-032 The round-robin selector SHALL be one sub-module, rr_pick2.

Verification
REQ-033 vblank=0, CPU writes 0x5A @0x4C0 -> RAM gets it same cycle; cpu_hold stays 0.
REQ-034 vblank=1, rq_req=01, read @0x3E8 holding 0x77 -> cpu_hold high for 2+3 cycles; rq_ack=01 in cycle 5, rq_rdata=0x77.
REQ-035 vblank=1, rq_req=11 both writes (0x11 @0x100, 0x22 @0x101) -> ack0 first, then ack1 3 cycles later; cpu_hold never drops between them.
REQ-036 vblank falls during XFER -> write completes, ack issued, IDLE next, cpu_hold=0; the pending other request waits for the next vblank.
REQ-037 RESET_N low during SETUP -> no ram_we, no ack, cpu_hold=0 immediately; after release with vblank=1, the request completes normally.
REQ-038 CPU write in the HOLD first cycle -> lands in RAM; no secondary ram_we overlaps it.

Source files
------------

// File: rtl/work_ram_arbiter_pkg.sv
// Shared definitions for the work RAM arbiter: FSM encoding, requester
// indices and the HOLD window length.
package work_ram_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    SETUP,
    XFER,
    DONE
  } state_e;

  // Requester indices into rq_req / rq_ack
  localparam logic RQ_HISCORE = 1'b0;
  localparam logic RQ_UPLOAD  = 1'b1;

  // CPU is stalled this many cycles before the first secondary access so
  // that an in-flight CPU write can still land.
  localparam int                HOLD_CYCLES = 2;
  localparam int                HOLD_CW     = 1;
  localparam logic [HOLD_CW-1:0] HOLD_LAST  = HOLD_CW'(HOLD_CYCLES - 1);

  // One-hot lane for a requester index
  function automatic logic [1:0] rq_onehot(input logic idx);
    return (idx == RQ_UPLOAD) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/work_ram_arbiter_if.sv
// Bundle of CPU request, secondary requesters and the muxed RAM port.
// slave: the arbiter; master: the surroundings (CPU, requesters, RAM).
interface work_ram_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 8
);
  logic          vblank;

  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_we;
  logic          cpu_hold;

  logic [1:0]    rq_req;
  logic [AW-1:0] rq_addr0;
  logic [AW-1:0] rq_addr1;
  logic [DW-1:0] rq_wdata0;
  logic [DW-1:0] rq_wdata1;
  logic [1:0]    rq_we;
  logic [1:0]    rq_ack;
  logic [DW-1:0] rq_rdata;

  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic [DW-1:0] ram_rdata;

  modport slave (
    input  vblank, cpu_addr, cpu_wdata, cpu_we,
    input  rq_req, rq_addr0, rq_addr1, rq_wdata0, rq_wdata1, rq_we,
    input  ram_rdata,
    output cpu_hold, rq_ack, rq_rdata, ram_addr, ram_wdata, ram_we
  );

  modport master (
    output vblank, cpu_addr, cpu_wdata, cpu_we,
    output rq_req, rq_addr0, rq_addr1, rq_wdata0, rq_wdata1, rq_we,
    output ram_rdata,
    input  cpu_hold, rq_ack, rq_rdata, ram_addr, ram_wdata, ram_we
  );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin selector: a lone requester wins; with both
// requesting, the one not served last wins.
module rr_pick2
  import work_ram_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       any_o,
  output logic       idx_o
);

  // Pick the winner index from the request vector and last-served index
  always_comb begin
    any_o = |req_i;
    case (req_i)
      2'b01:   idx_o = RQ_HISCORE;
      2'b10:   idx_o = RQ_UPLOAD;
      2'b11:   idx_o = ~last_i;
      default: idx_o = RQ_HISCORE;
    endcase
  end

endmodule

// File: rtl/work_ram_arbiter.sv
// Work RAM arbiter: the CPU owns the RAM port by default; during vblank the
// hiscore engine and the OSD upload reader borrow it, one access at a time,
// while the CPU is stalled through cpu_hold.
module work_ram_arbiter
  import work_ram_arbiter_pkg::*;
#(
  parameter int AW = 12,
  parameter int DW = 8
) (
  input logic               clk,
  input logic               RESET_N,
  work_ram_arbiter_if.slave bus
);

  state_e             state_q, state_d;
  logic [HOLD_CW-1:0] hold_cnt_q, hold_cnt_d;
  logic               win_q, win_d;
  logic               last_q, last_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic               we_q, we_d;
  logic [DW-1:0]      rdata_q, rdata_d;

  logic [1:0]         pick_req;
  logic               pick_any;
  logic               pick_idx;
  logic               sel_latch;

  // In DONE the requester being acked may still show rq_req; mask it so only
  // genuinely pending requests can chain into another access.
  assign pick_req = (state_q == DONE) ? (bus.rq_req & ~rq_onehot(win_q))
                                      : bus.rq_req;

  rr_pick2 u_pick (
    .req_i  (pick_req),
    .last_i (last_q),
    .any_o  (pick_any),
    .idx_o  (pick_idx)
  );

  // State register, winner/payload latches and read-data hold register
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      win_q      <= RQ_HISCORE;
      last_q     <= RQ_UPLOAD;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      rdata_q    <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      win_q      <= win_d;
      last_q     <= last_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      rdata_q    <= rdata_d;
    end
  end

  // Next-state logic plus winner/payload selection at HOLD entry or DONE
  always_comb begin
    // NOTE: hold-current defaults first, so no path leaves a latch behind.
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    win_d      = win_q;
    last_d     = last_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    rdata_d    = rdata_q;
    sel_latch  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.vblank && pick_any) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
          sel_latch  = 1'b1;
        end
      end
      HOLD: begin
        if (hold_cnt_q == HOLD_LAST) state_d = SETUP;
        else                         hold_cnt_d = hold_cnt_q + 1'b1;
      end
      SETUP: state_d = XFER;
      XFER:  state_d = DONE;
      DONE: begin
        rdata_d = bus.ram_rdata;
        if (bus.vblank && pick_any) begin
          state_d   = SETUP;
          sel_latch = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Payload is frozen here; later requester changes are ignored until ack
    if (sel_latch) begin
      win_d   = pick_idx;
      last_d  = pick_idx;
      addr_d  = (pick_idx == RQ_UPLOAD) ? bus.rq_addr1  : bus.rq_addr0;
      wdata_d = (pick_idx == RQ_UPLOAD) ? bus.rq_wdata1 : bus.rq_wdata0;
      we_d    = bus.rq_we[pick_idx];
    end
  end

  // RAM port mux, CPU stall, ack pulse and read data per state
  always_comb begin
    bus.ram_addr  = bus.cpu_addr;
    bus.ram_wdata = bus.cpu_wdata;
    bus.ram_we    = bus.cpu_we;
    bus.cpu_hold  = 1'b1;
    bus.rq_ack    = 2'b00;
    bus.rq_rdata  = rdata_q;

    case (state_q)
      IDLE: bus.cpu_hold = 1'b0;
      HOLD: ;  // CPU pass-through stays live so an in-flight write lands
      SETUP: begin
        bus.ram_addr  = addr_q;
        bus.ram_wdata = wdata_q;
        bus.ram_we    = 1'b0;
      end
      XFER: begin
        bus.ram_addr  = addr_q;
        bus.ram_wdata = wdata_q;
        bus.ram_we    = we_q;
      end
      DONE: begin
        bus.ram_addr  = addr_q;
        bus.ram_wdata = wdata_q;
        bus.ram_we    = 1'b0;
        bus.rq_ack    = rq_onehot(win_q);
        bus.rq_rdata  = bus.ram_rdata;
      end
      default: bus.cpu_hold = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_work_ram_arbiter.sv
// Directed bench for work_ram_arbiter: stimulus pushes expected acks into a
// scoreboard queue; a monitor pops and compares on every rq_ack pulse.
module tb_work_ram_arbiter;

  logic clk;
  logic RESET_N;

  work_ram_arbiter_if #(.AW(12), .DW(8)) bus ();

  work_ram_arbiter #(.AW(12), .DW(8)) dut (
    .clk     (clk),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Work RAM model with one-cycle synchronous read
  logic [7:0] mem [0:4095];
  always @(posedge clk) begin
    // NOTE: RAM contents are deliberately not reset, like the real block RAM.
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  typedef struct {
    logic       idx;
    logic       is_read;
    logic [7:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   samp;
  int   hold_cnt;
  int   ack_at [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every ack pulse must match the oldest expectation
  always @(negedge clk) begin
    if (bus.rq_ack != 2'b00) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", {30'b0, bus.rq_ack}, 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("ack_lane", {30'b0, bus.rq_ack}, e.idx ? 32'h2 : 32'h1);
        if (e.is_read) check("rq_rdata", {24'b0, bus.rq_rdata}, {24'b0, e.rdata});
      end
    end
  end

  task automatic push_exp(input logic idx, input logic is_read, input logic [7:0] rdata);
    exp_t e;
    e.idx = idx; e.is_read = is_read; e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  task automatic start_window();
    samp = 0; hold_cnt = 0; ack_at[0] = -1; ack_at[1] = -1;
  endtask

  // One clock: sample at negedge, count stall cycles, requesters drop on ack
  task automatic cycle();
    @(negedge clk);
    samp++;
    if (bus.cpu_hold) hold_cnt++;
    for (int i = 0; i < 2; i++) begin
      if (bus.rq_ack[i]) begin
        if (ack_at[i] < 0) ack_at[i] = samp;
        bus.rq_req[i] = 1'b0;
      end
    end
  endtask

  task automatic cpu_write(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.cpu_addr = a; bus.cpu_wdata = d; bus.cpu_we = 1'b1;
    @(negedge clk);
    bus.cpu_we = 1'b0;
  endtask

  initial begin
    RESET_N = 1'b0;
    bus.vblank = 1'b0;
    bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_we = 1'b0;
    bus.rq_req = 2'b00; bus.rq_we = 2'b00;
    bus.rq_addr0 = '0; bus.rq_addr1 = '0; bus.rq_wdata0 = '0; bus.rq_wdata1 = '0;
    start_window();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_cpu_hold", {31'b0, bus.cpu_hold}, 32'h0);
    check("rst_rq_ack", {30'b0, bus.rq_ack}, 32'h0);
    check("rst_rq_rdata", {24'b0, bus.rq_rdata}, 32'h0);
    RESET_N = 1'b1;

    // CPU write passes straight through outside vblank
    @(negedge clk);
    bus.cpu_addr = 12'h4C0; bus.cpu_wdata = 8'h5A; bus.cpu_we = 1'b1;
    #1;
    check("pass_addr", {20'b0, bus.ram_addr}, 32'h4C0);
    check("pass_wdata", {24'b0, bus.ram_wdata}, 32'h5A);
    check("pass_we", {31'b0, bus.ram_we}, 32'h1);
    check("pass_hold", {31'b0, bus.cpu_hold}, 32'h0);
    @(negedge clk);
    bus.cpu_we = 1'b0;
    check("pass_mem", {24'b0, mem[12'h4C0]}, 32'h5A);

    // Request outside vblank waits: no stall, no ack, no RAM effect
    bus.rq_req = 2'b10; bus.rq_addr1 = 12'h4C0; bus.rq_wdata1 = 8'hFF; bus.rq_we = 2'b10;
    start_window();
    repeat (6) cycle();
    check("novb_hold", hold_cnt, 0);
    check("novb_mem", {24'b0, mem[12'h4C0]}, 32'h5A);
    bus.rq_req = 2'b00;

    cpu_write(12'h3E8, 8'h77);
    cpu_write(12'h300, 8'hEE);

    // Both write in one window: bit0 first, bit1 three cycles later
    @(negedge clk);
    bus.cpu_addr = 12'h7FF; bus.cpu_wdata = 8'hAB; bus.cpu_we = 1'b1;
    bus.rq_addr0 = 12'h100; bus.rq_wdata0 = 8'h11;
    bus.rq_addr1 = 12'h101; bus.rq_wdata1 = 8'h22;
    bus.rq_we = 2'b11; bus.rq_req = 2'b11; bus.vblank = 1'b1;
    push_exp(1'b0, 1'b0, 8'h00);
    push_exp(1'b1, 1'b0, 8'h00);
    start_window();
    repeat (3) cycle();
    check("setup_addr", {20'b0, bus.ram_addr}, 32'h100);
    check("setup_wdata", {24'b0, bus.ram_wdata}, 32'h11);
    check("setup_we", {31'b0, bus.ram_we}, 32'h0);
    cycle();
    check("xfer_we", {31'b0, bus.ram_we}, 32'h1);
    check("xfer_addr", {20'b0, bus.ram_addr}, 32'h100);
    repeat (6) cycle();
    check("both_hold", hold_cnt, 8);
    check("both_ack0_at", ack_at[0], 5);
    check("both_ack1_at", ack_at[1], 8);
    check("both_mem0", {24'b0, mem[12'h100]}, 32'h11);
    check("both_mem1", {24'b0, mem[12'h101]}, 32'h22);
    bus.cpu_we = 1'b0; bus.vblank = 1'b0;

    // Single read: 2 HOLD + SETUP/XFER/DONE, ack in cycle 5 with data
    @(negedge clk);
    bus.rq_addr0 = 12'h3E8; bus.rq_we = 2'b00; bus.rq_req = 2'b01; bus.vblank = 1'b1;
    push_exp(1'b0, 1'b1, 8'h77);
    start_window();
    repeat (7) cycle();
    check("rd_hold", hold_cnt, 5);
    check("rd_ack0_at", ack_at[0], 5);
    bus.vblank = 1'b0;

    // vblank falls in XFER: current access (bit1, round-robin) finishes
    @(negedge clk);
    bus.rq_addr0 = 12'h200; bus.rq_wdata0 = 8'h33;
    bus.rq_addr1 = 12'h201; bus.rq_wdata1 = 8'h44;
    bus.rq_we = 2'b11; bus.rq_req = 2'b11; bus.vblank = 1'b1;
    push_exp(1'b1, 1'b0, 8'h00);
    start_window();
    repeat (4) cycle();
    check("vbf_xfer_addr", {20'b0, bus.ram_addr}, 32'h201);
    bus.vblank = 1'b0;
    repeat (2) cycle();
    check("vbf_idle_hold", {31'b0, bus.cpu_hold}, 32'h0);
    repeat (4) cycle();
    check("vbf_hold", hold_cnt, 5);
    check("vbf_ack1_at", ack_at[1], 5);
    check("vbf_ack0_none", ack_at[0], 32'hFFFF_FFFF);
    check("vbf_mem1", {24'b0, mem[12'h201]}, 32'h44);
    // Next window serves the waiting bit0
    bus.vblank = 1'b1;
    push_exp(1'b0, 1'b0, 8'h00);
    start_window();
    repeat (6) cycle();
    check("vbf_ack0_at", ack_at[0], 5);
    check("vbf_mem0", {24'b0, mem[12'h200]}, 32'h33);
    bus.vblank = 1'b0;

    // Reset during SETUP drops the access; it re-runs after release
    @(negedge clk);
    bus.rq_addr0 = 12'h300; bus.rq_wdata0 = 8'h55; bus.rq_we = 2'b01;
    bus.rq_req = 2'b01; bus.vblank = 1'b1;
    start_window();
    repeat (3) cycle();
    check("rs_setup_addr", {20'b0, bus.ram_addr}, 32'h300);
    RESET_N = 1'b0;
    #1;
    check("rs_hold", {31'b0, bus.cpu_hold}, 32'h0);
    check("rs_ack", {30'b0, bus.rq_ack}, 32'h0);
    check("rs_we", {31'b0, bus.ram_we}, 32'h0);
    repeat (2) @(negedge clk);
    check("rs_mem_kept", {24'b0, mem[12'h300]}, 32'hEE);
    RESET_N = 1'b1;
    push_exp(1'b0, 1'b0, 8'h00);
    start_window();
    repeat (6) cycle();
    check("rs_ack0_at", ack_at[0], 5);
    check("rs_mem", {24'b0, mem[12'h300]}, 32'h55);
    bus.vblank = 1'b0;

    // CPU write in the first HOLD cycle lands, no overlap with secondary
    @(negedge clk);
    bus.rq_addr0 = 12'h400; bus.rq_wdata0 = 8'h66; bus.rq_we = 2'b01;
    bus.cpu_addr = 12'h401; bus.cpu_wdata = 8'h99; bus.cpu_we = 1'b0;
    bus.rq_req = 2'b01; bus.vblank = 1'b1;
    push_exp(1'b0, 1'b0, 8'h00);
    start_window();
    cycle();
    bus.cpu_we = 1'b1;
    #1;
    check("hold_cpu_we", {31'b0, bus.ram_we}, 32'h1);
    check("hold_cpu_addr", {20'b0, bus.ram_addr}, 32'h401);
    check("hold_cpu_stall", {31'b0, bus.cpu_hold}, 32'h1);
    cycle();
    bus.cpu_we = 1'b0;
    repeat (4) cycle();
    check("hold_ack0_at", ack_at[0], 5);
    check("hold_mem_cpu", {24'b0, mem[12'h401]}, 32'h99);
    check("hold_mem_sec", {24'b0, mem[12'h400]}, 32'h66);
    bus.vblank = 1'b0;

    repeat (3) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
